// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin line-fill arbiter sharing one memory port between icache and dcache
module mem_arbiter #(
    parameter int ADDRSZ  = 64,
    parameter int BLOCKSZ = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [ADDRSZ-1:0]  i_addr,
    input  logic               d_req,
    input  logic [ADDRSZ-1:0]  d_addr,
    output logic [ADDRSZ-1:0]  mem_addr,
    output logic               mem_req,
    input  logic [BLOCKSZ-1:0] mem_data_in,
    input  logic               mem_data_valid,
    output logic [BLOCKSZ-1:0] line_out,
    output logic               i_valid,
    output logic               d_valid,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {SRC_I, SRC_D} src_t;

    state_t             state, state_nxt;
    src_t               gnt, gnt_nxt, last, last_nxt;
    logic [ADDRSZ-1:0]  mem_addr_nxt;
    logic [BLOCKSZ-1:0] line_nxt;

    // State, grant bookkeeping, latched address and returned line
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= SRC_I;
            last     <= SRC_D;
            mem_addr <= '0;
            line_out <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            last     <= last_nxt;
            mem_addr <= mem_addr_nxt;
            line_out <= line_nxt;
        end
    end

    // Next-state: grant in IDLE (ties go to whoever was not served last), capture line in WAIT
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        last_nxt     = last;
        mem_addr_nxt = mem_addr;
        line_nxt     = line_out;
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_nxt      = (i_req && d_req) ? ((last == SRC_I) ? SRC_D : SRC_I)
                                                    : (i_req ? SRC_I : SRC_D);
                    mem_addr_nxt = (gnt_nxt == SRC_I) ? i_addr : d_addr;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mem_data_valid) begin
                    line_nxt  = mem_data_in;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                last_nxt  = gnt;
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes decode purely from state so reset clears them immediately
    always_comb begin
        mem_req = (state == ISSUE);
        i_valid = (state == DONE) && (gnt == SRC_I);
        d_valid = (state == DONE) && (gnt == SRC_D);
        busy    = (state != IDLE);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          reset, i_req, d_req, mem_data_valid;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [BW-1:0] mem_data_in, line_out;
    logic          mem_req, i_valid, d_valid, busy;

    typedef struct {
        logic          is_i;
        logic [BW-1:0] line;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_arbiter #(.ADDRSZ(AW), .BLOCKSZ(BW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
        .line_out(line_out), .i_valid(i_valid), .d_valid(d_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [AW-1:0] addr);
        for (int n = 0; n < 20 && !mem_req; n++) step();
        chk({tag, "_mem_req"}, BW'(mem_req), BW'(1));
        chk({tag, "_mem_addr"}, BW'(mem_addr), BW'(addr));
    endtask

    task automatic finish_line(input string tag, input logic is_i, input logic [BW-1:0] data);
        exp_t e;
        mem_data_valid = 1'b1;
        mem_data_in    = data;
        sb.push_back('{is_i, data});
        step();
        mem_data_valid = 1'b0;
        e = sb.pop_front();
        chk({tag, "_i_valid"}, BW'(i_valid), BW'(e.is_i));
        chk({tag, "_d_valid"}, BW'(d_valid), BW'(!e.is_i));
        chk({tag, "_line"}, line_out, e.line);
    endtask

    task automatic transact(input string tag, input logic is_i, input logic [AW-1:0] addr,
                            input logic [BW-1:0] data, input int gap);
        wait_req(tag, addr);
        step();
        repeat (gap) step();
        finish_line(tag, is_i, data);
    endtask

    initial begin
        logic [BW-1:0] pat_a, pat_b, pat_prev;
        pat_a = {16{32'hA5A5_0001}};
        pat_b = {16{32'h5A5A_0002}};
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
        mem_data_valid = 1'b0; mem_data_in = '0;
        step(); step();
        chk("rst_mem_req", BW'(mem_req), BW'(0));
        chk("rst_busy", BW'(busy), BW'(0));
        chk("rst_valids", BW'({i_valid, d_valid}), BW'(0));
        chk("rst_line", line_out, '0);
        chk("rst_addr", BW'(mem_addr), BW'(0));
        reset = 1'b0;
        step();
        i_req = 1'b1; i_addr = 64'h1000;
        step();
        chk("single_mem_req", BW'(mem_req), BW'(1));
        chk("single_addr", BW'(mem_addr), BW'(64'h1000));
        chk("single_busy", BW'(busy), BW'(1));
        step();
        chk("single_req_pulse", BW'(mem_req), BW'(0));
        step(); step();
        finish_line("single", 1'b1, pat_a);
        i_req = 1'b0;
        step();
        chk("single_idle_busy", BW'(busy), BW'(0));
        chk("single_pulse_end", BW'({i_valid, d_valid}), BW'(0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 64'h2000; d_addr = 64'h8000;
        transact("tie_i", 1'b1, 64'h2000, pat_b, 1);
        i_req = 1'b0;
        step();
        chk("tie_gap_idle", BW'(mem_req), BW'(0));
        step();
        chk("tie_d_mem_req", BW'(mem_req), BW'(1));
        chk("tie_d_addr", BW'(mem_addr), BW'(64'h8000));
        transact("tie_d", 1'b0, 64'h8000, pat_a, 2);
        d_req = 1'b0;
        step();
        i_req = 1'b1; d_req = 1'b1; i_addr = 64'h5000; d_addr = 64'h6000;
        transact("rr0", 1'b1, 64'h5000, {16{32'h1111_0000}}, 0);
        transact("rr1", 1'b0, 64'h6000, {16{32'h2222_0000}}, 1);
        transact("rr2", 1'b1, 64'h5000, {16{32'h3333_0000}}, 3);
        transact("rr3", 1'b0, 64'h6000, {16{32'h4444_0000}}, 0);
        i_req = 1'b0; d_req = 1'b0;
        step();
        pat_prev = line_out;
        mem_data_valid = 1'b1; mem_data_in = BW'(16'hDEAD);
        step();
        mem_data_valid = 1'b0;
        chk("spur_valids", BW'({i_valid, d_valid}), BW'(0));
        chk("spur_line", line_out, pat_prev);
        chk("spur_busy", BW'(busy), BW'(0));
        i_req = 1'b1; i_addr = 64'h3000;
        wait_req("addr_chg", 64'h3000);
        step();
        i_addr = 64'h4000; i_req = 1'b0;
        step();
        chk("addr_chg_wait", BW'(mem_addr), BW'(64'h3000));
        finish_line("addr_chg", 1'b1, pat_b);
        chk("addr_chg_done", BW'(mem_addr), BW'(64'h3000));
        step();
        d_req = 1'b1; d_addr = 64'h7000;
        wait_req("rst_wait", 64'h7000);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; d_req = 1'b0;
        chk("rst_wait_busy", BW'(busy), BW'(0));
        chk("rst_wait_mem_req", BW'(mem_req), BW'(0));
        chk("rst_wait_line", line_out, '0);
        step();
        mem_data_valid = 1'b1; mem_data_in = pat_a;
        step();
        mem_data_valid = 1'b0;
        chk("rst_wait_valids", BW'({i_valid, d_valid}), BW'(0));
        chk("rst_wait_line2", line_out, '0);
        step();
        chk("rst_wait_valids2", BW'({i_valid, d_valid}), BW'(0));
        chk("rst_wait_idle", BW'({busy, mem_req}), BW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRSZ, default 64, request address width in bits.
REQ-002 Parameter BLOCKSZ, default 512, cache-line width in bits (64*8).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  instruction-cache line-fill request; held high until i_valid.
REQ-006 i_addr  input  ADDRSZ  instruction-cache fill address.
REQ-007 d_req  input  1  data-cache line-fill request; held high until d_valid.
REQ-008 d_addr  input  ADDRSZ  data-cache fill address.
REQ-009 mem_addr  output  ADDRSZ  address to the memory controller.
REQ-010 mem_req  output  1  start-request strobe to the memory controller.
REQ-011 mem_data_in  input  BLOCKSZ  line returned by the memory controller.
REQ-012 mem_data_valid  input  1  memory controller line-return strobe.
REQ-013 line_out  output  BLOCKSZ  returned line, shared by both requesters.
REQ-014 i_valid  output  1  one-cycle pulse: line_out holds the icache line.
REQ-015 d_valid  output  1  one-cycle pulse: line_out holds the dcache line.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-018 The FSM SHALL track the served requester in a register gnt (I or D) and the last served requester in a register last (I or D).
REQ-019 In IDLE with exactly one request high, the FSM SHALL set gnt to that requester, latch its address into mem_addr, and go to ISSUE.
REQ-020 In IDLE with both requests high, the FSM SHALL grant the requester that is not equal to last (round-robin).
REQ-021 In IDLE with no request high, the FSM SHALL stay in IDLE.
REQ-022 In ISSUE, mem_req SHALL be high for exactly one cycle, and the FSM SHALL go to WAIT.
REQ-023 mem_req SHALL be low in every state other than ISSUE.
REQ-024 mem_addr SHALL hold the latched address from ISSUE until the next grant.
REQ-025 In WAIT, the FSM SHALL stay until mem_data_valid is high; it SHALL then register mem_data_in into line_out and go to DONE.
REQ-026 In DONE, the FSM SHALL pulse i_valid if gnt is I, or d_valid if gnt is D, set last to gnt, and go to IDLE.
REQ-027 i_valid and d_valid SHALL never be high in the same cycle.
REQ-028 In DONE, the FSM SHALL sample no requests, so the just-served requester has one cycle to drop its req.
REQ-029 Latency: req sampled in IDLE at cycle N gives mem_req at N+1; mem_data_valid at cycle M gives the valid pulse at M+1.
REQ-030 mem_data_valid SHALL be ignored in IDLE, ISSUE and DONE; line_out SHALL then keep its value.
REQ-031 A requester dropping req during ISSUE or WAIT SHALL NOT abort the transaction; its valid pulse SHALL still be issued.
REQ-032 Address inputs SHALL be sampled only in the IDLE grant cycle; later changes SHALL have no effect on the transaction in flight.
REQ-033 line_out SHALL change only on the WAIT-to-DONE transition.

Reset
REQ-034 Reset SHALL force state to IDLE, gnt to I, last to D (icache wins the first tie), and mem_addr to 0.
REQ-035 Reset SHALL force line_out to 0, and mem_req, i_valid, d_valid and busy to 0.
REQ-036 Reset asserted mid-transaction (ISSUE or WAIT) SHALL abandon the transaction; no valid pulse SHALL follow.
REQ-037 After reset is released, the FSM SHALL ignore any mem_data_valid of the abandoned transaction, because the FSM is then in IDLE.

Verification
REQ-038 Single icache request: i_req=1 with i_addr=0x1000 at cycle 0 -> mem_req=1, mem_addr=0x1000 at cycle 1; mem_data_valid at cycle 5 with pattern A -> i_valid=1, line_out=A at cycle 6; d_valid stays 0.
REQ-039 Tie after reset: i_req=d_req=1, i_addr=0x2000, d_addr=0x8000 -> icache is served first (mem_addr=0x2000); then, with d_req still high, the data request is issued (mem_addr=0x8000) two cycles after i_valid.
REQ-040 Round-robin: both requesters continuously high for 4 transactions -> grant order I, D, I, D; no request starved.
REQ-041 Spurious return: mem_data_valid=1 in IDLE with data 0xDEAD -> no valid pulse; line_out unchanged; busy=0.
REQ-042 Reset in WAIT: assert reset for 1 cycle, then drive mem_data_valid 2 cycles later -> no i_valid or d_valid; mem_req=0; state IDLE.
REQ-043 Address change: i_addr changes from 0x3000 to 0x4000 during WAIT -> mem_addr stays 0x3000 until DONE.
